// File: rtl/flash_mp_pkg.sv
// Shared types for the flash memory-protection data-region table.
// Used by the region config block and by the per-port region selectors.
package flash_mp_pkg;

    localparam int MpNumRegions = 8;
    localparam int MpAddrW      = 9;
    localparam int IdxW         = $clog2(MpNumRegions);

    typedef struct packed {
        logic rd_en;
        logic prog_en;
        logic erase_en;
        logic ecc_en;
    } data_region_attr_t;

    typedef struct packed {
        logic                lock;
        logic                en;
        data_region_attr_t   attr;
        logic [MpAddrW:0]    size;
        logic [MpAddrW-1:0]  base;
    } region_cfg_t;

    localparam int RegW = $bits(region_cfg_t);

    typedef enum logic {
        StIdle,
        StStaged
    } shadow_state_e;

    // The region must end at or below the top of the page space.
    function automatic logic range_ok(region_cfg_t cfg);
        logic [MpAddrW:0] span_end;
        span_end = {1'b0, cfg.base} + cfg.size;
        return span_end <= {1'b1, {MpAddrW{1'b0}}};
    endfunction

endpackage

// File: rtl/flash_mp_region_cfg_if.sv
// Config access bus of the region table: request/grant in, registered response out.
interface flash_mp_region_cfg_if;
    import flash_mp_pkg::*;

    logic             req;
    logic             we;
    logic [IdxW-1:0]  idx;
    region_cfg_t      wdata;
    logic             gnt;
    logic             ack;
    logic             err;
    region_cfg_t      rdata;

    modport master (output req, we, idx, wdata, input gnt, ack, err, rdata);
    modport slave  (input req, we, idx, wdata, output gnt, ack, err, rdata);

endinterface

// File: rtl/flash_mp_region_shadow.sv
// Shadowed two-write commit: first write stages {idx,data}, an identical second write commits.
module flash_mp_region_shadow
    import flash_mp_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [IdxW-1:0]  idx_i,
    input  region_cfg_t      wdata_i,
    input  logic             locked_i,
    output logic             commit_o,
    output logic [IdxW-1:0]  commit_idx_o,
    output region_cfg_t      commit_data_o,
    output logic             err_o,
    output logic             mismatch_o
);

    shadow_state_e   state_q, state_d;
    logic [IdxW-1:0] stage_idx_q, stage_idx_d;
    region_cfg_t     stage_data_q, stage_data_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d      = state_q;
        stage_idx_d  = stage_idx_q;
        stage_data_d = stage_data_q;
        commit_o     = 1'b0;
        err_o        = 1'b0;
        mismatch_o   = 1'b0;
        if (wr_i) begin
            unique case (state_q)
                StIdle: begin
                    if (locked_i) begin
                        err_o = 1'b1;
                    end else begin
                        stage_idx_d  = idx_i;
                        stage_data_d = wdata_i;
                        state_d      = StStaged;
                    end
                end
                StStaged: begin
                    state_d      = StIdle;
                    stage_idx_d  = '0;
                    stage_data_d = '0;
                    if (idx_i == stage_idx_q && wdata_i == stage_data_q) begin
                        commit_o = range_ok(stage_data_q);
                        err_o    = ~range_ok(stage_data_q);
                    end else begin
                        err_o      = 1'b1;
                        mismatch_o = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign commit_idx_o  = stage_idx_q;
    assign commit_data_o = stage_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q      <= StIdle;
            stage_idx_q  <= '0;
            stage_data_q <= '0;
        end else begin
            state_q      <= state_d;
            stage_idx_q  <= stage_idx_d;
            stage_data_q <= stage_data_d;
        end
    end

endmodule

// File: rtl/flash_mp_region_cfg.sv
// Write side of the flash MP data-region table: init sweep, entry array,
// lock handling and the registered config response.
module flash_mp_region_cfg
    import flash_mp_pkg::*;
#(
    parameter int   NumRegions = MpNumRegions,
    parameter int   AddrW      = MpAddrW,
    parameter logic HwDataAttr = 1'b1,
    localparam int  TableW     = NumRegions * (2 * AddrW + 7)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    flash_mp_region_cfg_if.slave cfg,
    output logic                 init_done_o,
    output logic                 shadow_err_o,
    output logic [TableW-1:0]    region_cfg_o
);

    region_cfg_t     entries_q [NumRegions];
    region_cfg_t     entries_d [NumRegions];
    logic [IdxW-1:0] count_q, count_d;
    logic            init_done_q, init_done_d;
    logic            shadow_err_q, shadow_err_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    region_cfg_t     rdata_q, rdata_d;

    logic            accept, idx_ok, sh_wr;
    logic            sh_commit, sh_err, sh_mismatch;
    logic [IdxW-1:0] sh_commit_idx;
    region_cfg_t     sh_commit_data, sel_entry, default_entry;

    assign accept    = cfg.req & init_done_q;
    assign idx_ok    = 32'(cfg.idx) < NumRegions;
    assign sel_entry = idx_ok ? entries_q[cfg.idx] : '0;
    assign sh_wr     = accept & cfg.we & idx_ok;

    always_comb begin
        default_entry            = '0;
        default_entry.attr.rd_en = HwDataAttr;
    end

    flash_mp_region_shadow u_shadow (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_i          (sh_wr),
        .idx_i         (cfg.idx),
        .wdata_i       (cfg.wdata),
        .locked_i      (sel_entry.lock),
        .commit_o      (sh_commit),
        .commit_idx_o  (sh_commit_idx),
        .commit_data_o (sh_commit_data),
        .err_o         (sh_err),
        .mismatch_o    (sh_mismatch)
    );

    // The init sweep owns the array until it finishes; commits only land afterwards.
    always_comb begin
        entries_d   = entries_q;
        count_d     = count_q;
        init_done_d = init_done_q;
        if (!init_done_q) begin
            entries_d[count_q] = default_entry;
            count_d            = count_q + 1'b1;
            if (32'(count_q) == NumRegions - 1) begin
                init_done_d = 1'b1;
            end
        end else if (sh_commit) begin
            entries_d[sh_commit_idx] = sh_commit_data;
        end
    end

    always_comb begin
        ack_d        = accept;
        err_d        = accept & (~idx_ok | (cfg.we & sh_err));
        rdata_d      = (accept & ~cfg.we) ? sel_entry : '0;
        shadow_err_d = shadow_err_q | sh_mismatch;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the entry array is reset because the table must read all-zero until the sweep runs.
            for (int i = 0; i < NumRegions; i++) begin
                entries_q[i] <= '0;
            end
            count_q      <= '0;
            init_done_q  <= 1'b0;
            shadow_err_q <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            entries_q    <= entries_d;
            count_q      <= count_d;
            init_done_q  <= init_done_d;
            shadow_err_q <= shadow_err_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign cfg.gnt      = init_done_q;
    assign cfg.ack      = ack_q;
    assign cfg.err      = err_q;
    assign cfg.rdata    = rdata_q;
    assign init_done_o  = init_done_q;
    assign shadow_err_o = shadow_err_q;

    always_comb begin
        region_cfg_o = '0;
        for (int i = 0; i < NumRegions; i++) begin
            region_cfg_o[i*RegW +: RegW] = entries_q[i];
        end
    end

endmodule

// File: tb/tb_flash_mp_region_cfg.sv
// Directed bench for flash_mp_region_cfg: init sweep, shadow commit, lock, range and reset cases.
module tb_flash_mp_region_cfg;
    import flash_mp_pkg::*;

    localparam int TW = 8 * RegW;
    // Init value of every entry: only attr.rd_en (bit 22) set.
    localparam logic [24:0] DEF = 25'h40_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done, shadow_err;
    logic [TW-1:0] table_w;
    int            checks = 0;
    int            errors = 0;

    logic          r_ack, r_err;
    region_cfg_t   r_rdata;

    flash_mp_region_cfg_if cfg_if ();

    flash_mp_region_cfg #(
        .NumRegions (8),
        .AddrW      (9),
        .HwDataAttr (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg          (cfg_if),
        .init_done_o  (init_done),
        .shadow_err_o (shadow_err),
        .region_cfg_o (table_w)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic region_cfg_t mk(logic lock, logic en, logic [3:0] attr, int size, int base);
        region_cfg_t r;
        r.lock = lock;
        r.en   = en;
        r.attr = attr;
        r.size = size[9:0];
        r.base = base[8:0];
        return r;
    endfunction

    function automatic region_cfg_t entry(int i);
        return table_w[i*RegW +: RegW];
    endfunction

    // Called #1 after an edge; returns #1 after the accepting edge with the response captured.
    task automatic access(logic we, int idx, region_cfg_t data);
        cfg_if.req   = 1'b1;
        cfg_if.we    = we;
        cfg_if.idx   = idx[2:0];
        cfg_if.wdata = data;
        @(posedge clk);
        #1;
        cfg_if.req = 1'b0;
        r_ack   = cfg_if.ack;
        r_err   = cfg_if.err;
        r_rdata = cfg_if.rdata;
    endtask

    region_cfg_t d3, da, db, dl, r1, r2, dx, ds;

    initial begin
        cfg_if.req   = 1'b0;
        cfg_if.we    = 1'b0;
        cfg_if.idx   = '0;
        cfg_if.wdata = '0;
        d3 = mk(1'b0, 1'b1, 4'b1000, 32, 16);
        da = mk(1'b0, 1'b1, 4'b1000, 4, 8);
        db = mk(1'b0, 1'b1, 4'b1000, 4, 9);
        dl = mk(1'b1, 1'b1, 4'b1100, 8, 64);
        r1 = mk(1'b0, 1'b1, 4'b1000, 20, 500);
        r2 = mk(1'b0, 1'b1, 4'b1000, 20, 492);
        dx = mk(1'b0, 1'b1, 4'b1010, 3, 7);
        ds = mk(1'b0, 1'b1, 4'b1001, 2, 100);

        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", init_done, 1'b0);
        check("rst_gnt", cfg_if.gnt, 1'b0);
        check("rst_ack", cfg_if.ack, 1'b0);
        check("rst_table", table_w, '0);

        // Request held high across the sweep must be ignored.
        cfg_if.req   = 1'b1;
        cfg_if.we    = 1'b1;
        cfg_if.idx   = 3'd0;
        cfg_if.wdata = mk(1'b1, 1'b1, 4'hF, 1, 1);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("init_gnt_c%0d", k), cfg_if.gnt, (k == 8));
            check($sformatf("init_ack_c%0d", k), cfg_if.ack, 1'b0);
        end
        cfg_if.req = 1'b0;
        check("init_done", init_done, 1'b1);
        check("init_table", table_w, {8{DEF}});

        // Shadowed commit of entry 3.
        access(1'b1, 3, d3);
        check("w3a_ack", r_ack, 1'b1);
        check("w3a_err", r_err, 1'b0);
        check("w3a_entry", entry(3), DEF);
        access(1'b1, 3, d3);
        check("w3b_ack", r_ack, 1'b1);
        check("w3b_err", r_err, 1'b0);
        check("w3b_entry", entry(3), d3);
        access(1'b0, 3, '0);
        check("r3_err", r_err, 1'b0);
        check("r3_data", r_rdata, d3);
        @(posedge clk);
        #1;
        check("ack_single", cfg_if.ack, 1'b0);
        check("rdata_idle", cfg_if.rdata, '0);

        // Shadow mismatch on entry 2.
        check("shadow_err_pre", shadow_err, 1'b0);
        access(1'b1, 2, da);
        check("w2a_err", r_err, 1'b0);
        access(1'b1, 2, db);
        check("w2b_err", r_err, 1'b1);
        check("shadow_err_set", shadow_err, 1'b1);
        check("w2_entry", entry(2), DEF);

        // Lock entry 5, then try to overwrite it.
        access(1'b1, 5, dl);
        check("w5a_err", r_err, 1'b0);
        access(1'b1, 5, dl);
        check("w5b_err", r_err, 1'b0);
        check("w5_entry", entry(5), dl);
        access(1'b1, 5, mk(1'b0, 1'b0, 4'b0000, 0, 0));
        check("w5_locked_err", r_err, 1'b1);
        access(1'b1, 5, mk(1'b0, 1'b0, 4'b0000, 0, 0));
        check("w5_locked_err2", r_err, 1'b1);
        check("w5_entry_kept", entry(5), dl);

        // Range check: 500+20 overruns 512, 492+20 ends exactly at 512.
        access(1'b1, 4, r1);
        check("w4r1a_err", r_err, 1'b0);
        access(1'b1, 4, r1);
        check("w4r1b_err", r_err, 1'b1);
        check("w4r1_entry", entry(4), DEF);
        access(1'b1, 4, r2);
        check("w4r2a_err", r_err, 1'b0);
        access(1'b1, 4, r2);
        check("w4r2b_err", r_err, 1'b0);
        check("w4r2_entry", entry(4), r2);

        // Back-to-back: stage idx1, read idx6, commit idx1.
        access(1'b1, 1, dx);
        check("bb1_ack", r_ack, 1'b1);
        check("bb1_err", r_err, 1'b0);
        access(1'b0, 6, '0);
        check("bb2_ack", r_ack, 1'b1);
        check("bb2_err", r_err, 1'b0);
        check("bb2_rdata", r_rdata, DEF);
        check("bb2_entry1", entry(1), DEF);
        access(1'b1, 1, dx);
        check("bb3_ack", r_ack, 1'b1);
        check("bb3_err", r_err, 1'b0);
        check("bb3_entry1", entry(1), dx);

        // Reset while STAGED clears the table and the stage.
        access(1'b1, 7, ds);
        check("w7a_err", r_err, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_table", table_w, '0);
        check("mid_rst_init_done", init_done, 1'b0);
        check("mid_rst_shadow_err", shadow_err, 1'b0);
        check("mid_rst_gnt", cfg_if.gnt, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("reinit_done", init_done, 1'b1);
        check("reinit_table", table_w, {8{DEF}});
        access(1'b1, 7, ds);
        check("w7b_err", r_err, 1'b0);
        check("w7b_entry_staged_only", entry(7), DEF);
        access(1'b1, 7, ds);
        check("w7c_err", r_err, 1'b0);
        check("w7c_entry", entry(7), ds);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
